// File: rtl/eth_frame_sequencer.sv
// Ethernet frame byte sequencer: preamble, SFD, latched header, streamed payload,
// optional CRC-32 FCS and a fixed inter-frame gap, over a valid/ready byte stream.

package ethernet_header_pkg;
  typedef struct packed {
    logic [0:5][7:0] mac_destination;
    logic [0:5][7:0] mac_source;
    logic [0:1][7:0] eth_type_length;
  } ethernet_header;
endpackage

module eth_frame_sequencer
  import ethernet_header_pkg::*;
#(
  parameter int PACKET_PAYLOAD_BYTES = 128,
  parameter int IFG_BYTES            = 12,
  parameter int INCLUDE_FCS          = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  ethernet_header header_in,
  input  logic [7:0]     payload_data,
  input  logic           payload_valid,
  output logic           payload_ready,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic           tx_last,
  output logic           busy
);

  if (PACKET_PAYLOAD_BYTES < 46 || PACKET_PAYLOAD_BYTES > 1500) begin : g_bad_payload
    $error("eth_frame_sequencer: PACKET_PAYLOAD_BYTES must be 46..1500");
  end
  if (IFG_BYTES < 0 || IFG_BYTES > 65535) begin : g_bad_ifg
    $error("eth_frame_sequencer: IFG_BYTES must be 0..65535");
  end

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, FCS, IFG
  } state_t;

  localparam logic [15:0] PL_LAST  = 16'(PACKET_PAYLOAD_BYTES - 1);
  localparam logic [15:0] IFG_LAST = (IFG_BYTES > 0) ? 16'(IFG_BYTES - 1) : 16'd0;
  localparam state_t POST_FCS      = (IFG_BYTES > 0) ? IFG : IDLE;
  localparam state_t POST_PAYLOAD  = (INCLUDE_FCS != 0) ? FCS : POST_FCS;

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [31:0]     crc_q, crc_d;
  ethernet_header  hdr_q, hdr_d;
  logic [0:13][7:0] hdr_bytes;
  logic [31:0]     fcs;
  logic            xfer;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  assign hdr_bytes = hdr_q;
  assign fcs       = ~crc_q;
  assign xfer      = tx_valid && tx_ready;

  // Outputs depend only on state and counter, so they hold while a byte is stalled.
  always_comb begin
    tx_valid      = 1'b0;
    tx_data       = 8'h00;
    tx_last       = 1'b0;
    payload_ready = 1'b0;
    busy          = (state_q != IDLE);
    case (state_q)
      PREAMBLE: begin
        tx_valid = 1'b1;
        tx_data  = 8'h55;
      end
      SFD: begin
        tx_valid = 1'b1;
        tx_data  = 8'hD5;
      end
      HEADER: begin
        tx_valid = 1'b1;
        tx_data  = hdr_bytes[cnt_q[3:0]];
      end
      PAYLOAD: begin
        tx_valid      = payload_valid;
        tx_data       = payload_data;
        payload_ready = tx_ready;
        tx_last       = (INCLUDE_FCS == 0) && (cnt_q == PL_LAST);
      end
      FCS: begin
        tx_valid = 1'b1;
        tx_last  = (cnt_q[1:0] == 2'd3);
        case (cnt_q[1:0])
          2'd0:    tx_data = fcs[7:0];
          2'd1:    tx_data = fcs[15:8];
          2'd2:    tx_data = fcs[23:16];
          default: tx_data = fcs[31:24];
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    hdr_d   = hdr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          hdr_d   = header_in;
          crc_d   = 32'hFFFF_FFFF;
          cnt_d   = '0;
          state_d = PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (xfer) begin
          if (cnt_q == 16'd6) begin
            cnt_d   = '0;
            state_d = SFD;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      SFD: begin
        if (xfer) begin
          cnt_d   = '0;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (xfer) begin
          crc_d = crc32_byte(crc_q, tx_data);
          if (cnt_q == 16'd13) begin
            cnt_d   = '0;
            state_d = PAYLOAD;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          crc_d = crc32_byte(crc_q, tx_data);
          if (cnt_q == PL_LAST) begin
            cnt_d   = '0;
            state_d = POST_PAYLOAD;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      FCS: begin
        if (xfer) begin
          if (cnt_q[1:0] == 2'd3) begin
            cnt_d   = '0;
            state_d = POST_FCS;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      IFG: begin
        // The gap runs on wall-clock cycles, independent of tx_ready.
        if (cnt_q == IFG_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      crc_q   <= 32'hFFFF_FFFF;
      hdr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      hdr_q   <= hdr_d;
    end
  end

endmodule

// File: tb/tb_eth_frame_sequencer.sv
// Self-checking bench for eth_frame_sequencer: a frame-level byte model feeds a
// per-cycle compare process; directed scenarios cover reset, stalls, back-to-back and no-FCS builds.

module tb_eth_frame_sequencer;
  import ethernet_header_pkg::*;

  localparam int PL  = 128;
  localparam int HDR = 22;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, start;
  ethernet_header header_in;
  logic [7:0]     payload_data;
  logic           payload_valid, payload_ready;
  logic [7:0]     tx_data;
  logic           tx_valid, tx_ready, tx_last, busy;

  logic           start_nf, payload_valid_nf, payload_ready_nf, tx_ready_nf;
  logic           tx_valid_nf, tx_last_nf, busy_nf;
  logic [7:0]     payload_data_nf, tx_data_nf;

  eth_frame_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .header_in(header_in),
    .payload_data(payload_data), .payload_valid(payload_valid), .payload_ready(payload_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last), .busy(busy)
  );

  eth_frame_sequencer #(.PACKET_PAYLOAD_BYTES(46), .IFG_BYTES(12), .INCLUDE_FCS(0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .start(start_nf), .header_in(header_in),
    .payload_data(payload_data_nf), .payload_valid(payload_valid_nf), .payload_ready(payload_ready_nf),
    .tx_data(tx_data_nf), .tx_valid(tx_valid_nf), .tx_ready(tx_ready_nf), .tx_last(tx_last_nf),
    .busy(busy_nf)
  );

  int   tests = 0;
  int   fails = 0;
  int   pos = 0;
  ent_t exp_q[$];
  ent_t cap_q[$];
  bit   rand_ready = 1'b0;
  bit   rand_gap = 1'b0;
  ethernet_header hdr_a, hdr_b, hdr_c;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic failNow(input string name, input int act, input int req);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  // Plain reflected CRC-32 register update over a byte list (no final inversion).
  function automatic logic [31:0] crcReg(input logic [7:0] bytes[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (bytes[i]) begin
      c ^= {24'd0, bytes[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic buildFrame(input ethernet_header h, input int pl, input bit fcs_en,
                            input logic [7:0] base, output ent_t f[$]);
    logic [0:13][7:0] hb;
    logic [7:0]       body[$];
    logic [31:0]      c;
    f  = {};
    hb = h;
    repeat (7) f.push_back({8'h55, 1'b0});
    f.push_back({8'hD5, 1'b0});
    for (int i = 0; i < 14; i++) body.push_back(hb[i]);
    for (int i = 0; i < pl; i++) body.push_back(base + 8'(i));
    foreach (body[i]) f.push_back({body[i], 1'b0});
    if (fcs_en) begin
      c = ~crcReg(body);
      for (int k = 0; k < 4; k++) f.push_back({c[8*k +: 8], k == 3});
    end else begin
      f[f.size() - 1] = {body[body.size() - 1], 1'b1};
    end
  endtask

  task automatic queueFrame(input ethernet_header h);
    ent_t f[$];
    buildFrame(h, PL, 1'b1, 8'h00, f);
    foreach (f[i]) exp_q.push_back(f[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input ethernet_header h);
    start     = s;
    header_in = h;
  endtask

  task automatic waitEmpty(input int limit, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) failNow(name, exp_q.size(), 0);
  endtask

  // Payload source: bytes 0..PL-1 in order, advancing on each accepted byte.
  initial begin
    int  pay_idx;
    bit  fire, rst_seen;
    pay_idx       = 0;
    tx_ready      = 1'b1;
    payload_valid = 1'b1;
    payload_data  = 8'h00;
    forever begin
      @(negedge clk);
      fire     = payload_valid && payload_ready;
      rst_seen = !rst_n;
      @(posedge clk);
      #1;
      if (rst_seen) pay_idx = 0;
      else if (fire) pay_idx = (pay_idx + 1) % PL;
      tx_ready      = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      payload_valid = rand_gap ? ($urandom_range(0, 3) != 0) : 1'b1;
      payload_data  = 8'(pay_idx);
    end
  end

  // Compare process: every cycle against the frame model.
  logic [7:0] prev_data;
  logic       prev_last;
  bit         prev_stall = 1'b0;
  bit         prev_pl = 1'b0;
  always @(negedge clk) begin
    bit   in_pl;
    ent_t e;
    if (!rst_n) begin
      exp_q.delete();
      pos        = 0;
      prev_stall = 1'b0;
    end else begin
      in_pl = exp_q.size() > 0 && pos >= HDR && pos < HDR + PL;
      checkOutput("payload_ready", 32'(payload_ready), 32'(in_pl ? tx_ready : 1'b0));
      if (in_pl) checkOutput("tx_valid_passthru", 32'(tx_valid), 32'(payload_valid));
      if (prev_stall && !prev_pl) begin
        checkOutput("hold_data", 32'(tx_data), 32'(prev_data));
        checkOutput("hold_last", 32'(tx_last), 32'(prev_last));
      end
      if (tx_valid && tx_ready) begin
        cap_q.push_back({tx_data, tx_last});
        if (exp_q.size() == 0) begin
          failNow("unexpected_byte", int'(tx_data), -1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("tx_data", 32'(tx_data), 32'(e.d));
          checkOutput("tx_last", 32'(tx_last), 32'(e.last));
          pos = e.last ? 0 : pos + 1;
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_pl    = in_pl;
      prev_data  = tx_data;
      prev_last  = tx_last;
    end
  end

  initial begin
    logic [7:0]  hdr_lit[14];
    logic [7:0]  bytes[$];
    logic [7:0]  ascii[$];
    logic [31:0] c;
    ent_t        nexp[$];
    ent_t        ncap[$];
    int          n, idx;
    bit          done;

    hdr_lit = '{8'h8C, 8'h47, 8'hBE, 8'h1C, 8'h82, 8'hED, 8'h00, 8'h18, 8'h3E, 8'h01,
                8'hEB, 8'h6E, 8'h00, 8'h80};
    hdr_a.mac_destination = {8'h8C, 8'h47, 8'hBE, 8'h1C, 8'h82, 8'hED};
    hdr_a.mac_source      = {8'h00, 8'h18, 8'h3E, 8'h01, 8'hEB, 8'h6E};
    hdr_a.eth_type_length = {8'h00, 8'h80};
    hdr_b.mac_destination = {8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    hdr_b.mac_source      = {8'h02, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    hdr_b.eth_type_length = {8'h08, 8'h00};
    hdr_c                 = hdr_a;
    hdr_c.eth_type_length = {8'h00, 8'h2E};

    // Pin the model CRC against the standard check value.
    ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    checkOutput("crc_model_check", ~crcReg(ascii), 32'hCBF4_3926);

    rst_n            = 1'b0;
    start_nf         = 1'b0;
    payload_valid_nf = 1'b1;
    tx_ready_nf      = 1'b1;
    payload_data_nf  = 8'h00;
    applyStimulus(1'b0, hdr_a);
    repeat (3) tick();
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_tx_last", 32'(tx_last), 32'd0);
    checkOutput("rst_payload_ready", 32'(payload_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);

    // Scenario 1: start on the first cycle out of reset, header changed afterwards.
    cap_q = {};
    rst_n = 1'b1;
    queueFrame(hdr_a);
    applyStimulus(1'b1, hdr_a);
    tick();
    applyStimulus(1'b0, hdr_b);
    repeat (60) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    waitEmpty(2000, "frame1_timeout");
    for (int i = 0; i < 12; i++) begin
      checkOutput("ifg_busy", 32'(busy), 32'd1);
      checkOutput("ifg_tx_valid", 32'(tx_valid), 32'd0);
      if (i == 3) start = 1'b1;
      if (i == 5) start = 1'b0;
      tick();
    end
    checkOutput("idle_after_ifg", 32'(busy), 32'd0);
    repeat (20) tick();
    checkOutput("frame1_len", 32'(cap_q.size()), 32'd154);
    if (cap_q.size() == 154) begin
      for (int i = 0; i < 7; i++) checkOutput("preamble", 32'(cap_q[i].d), 32'h55);
      checkOutput("sfd", 32'(cap_q[7].d), 32'hD5);
      for (int i = 0; i < 14; i++) checkOutput("header_lit", 32'(cap_q[8 + i].d), 32'(hdr_lit[i]));
      checkOutput("last_on_154", 32'(cap_q[153].last), 32'd1);
      checkOutput("not_last_153", 32'(cap_q[152].last), 32'd0);
      bytes = {};
      for (int i = 8; i < 150; i++) bytes.push_back(cap_q[i].d);
      c = ~crcReg(bytes);
      checkOutput("fcs_value", {cap_q[153].d, cap_q[152].d, cap_q[151].d, cap_q[150].d}, c);
      for (int i = 150; i < 154; i++) bytes.push_back(cap_q[i].d);
      checkOutput("crc_residue", crcReg(bytes), 32'hDEBB_20E3);
    end

    // Scenario 2: random backpressure and payload gaps.
    cap_q      = {};
    rand_ready = 1'b1;
    rand_gap   = 1'b1;
    queueFrame(hdr_a);
    applyStimulus(1'b1, hdr_a);
    tick();
    applyStimulus(1'b0, hdr_a);
    waitEmpty(6000, "frame2_timeout");
    rand_ready = 1'b0;
    rand_gap   = 1'b0;
    repeat (20) tick();
    checkOutput("frame2_len", 32'(cap_q.size()), 32'd154);

    // Scenario 3: start held high, second frame picks up the new header.
    queueFrame(hdr_a);
    queueFrame(hdr_b);
    applyStimulus(1'b1, hdr_a);
    tick();
    applyStimulus(1'b1, hdr_b);
    n = 0;
    while (exp_q.size() > 154 && n < 2000) begin
      tick();
      n++;
    end
    if (exp_q.size() > 154) failNow("frame3a_timeout", exp_q.size(), 154);
    n = 0;
    while (!tx_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput("b2b_gap", 32'(n), 32'd13);
    applyStimulus(1'b0, hdr_b);
    waitEmpty(2000, "frame3b_timeout");
    repeat (20) tick();

    // Scenario 4: reset during payload byte 40, then a clean frame.
    queueFrame(hdr_a);
    applyStimulus(1'b1, hdr_a);
    tick();
    applyStimulus(1'b0, hdr_a);
    n = 0;
    while (pos != HDR + 40 && n < 500) begin
      tick();
      n++;
    end
    if (pos != HDR + 40) failNow("reach_payload40", pos, HDR + 40);
    rst_n = 1'b0;
    tick();
    checkOutput("midrst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_payload_ready", 32'(payload_ready), 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    cap_q = {};
    queueFrame(hdr_a);
    applyStimulus(1'b1, hdr_a);
    tick();
    applyStimulus(1'b0, hdr_a);
    waitEmpty(2000, "frame4_timeout");
    repeat (20) tick();
    checkOutput("frame4_len", 32'(cap_q.size()), 32'd154);

    // Scenario 5: no-FCS build with a 46-byte payload.
    buildFrame(hdr_c, 46, 1'b0, 8'hA0, nexp);
    header_in = hdr_c;
    start_nf  = 1'b1;
    tick();
    start_nf = 1'b0;
    idx  = 0;
    n    = 0;
    done = 1'b0;
    while (!done && n < 400) begin
      payload_data_nf = 8'hA0 + 8'(idx);
      @(negedge clk);
      if (tx_valid_nf && tx_ready_nf) begin
        ncap.push_back({tx_data_nf, tx_last_nf});
        if (tx_last_nf) done = 1'b1;
      end
      if (payload_valid_nf && payload_ready_nf) idx++;
      tick();
      n++;
    end
    if (!done) failNow("nf_timeout", ncap.size(), 68);
    checkOutput("nf_len", 32'(ncap.size()), 32'd68);
    if (ncap.size() == 68) begin
      for (int i = 0; i < 68; i++) checkOutput("nf_byte", 32'(ncap[i]), 32'(nexp[i]));
      checkOutput("nf_len_hi", 32'(ncap[20].d), 32'h00);
      checkOutput("nf_len_lo", 32'(ncap[21].d), 32'h2E);
      checkOutput("nf_last_payload", 32'({ncap[67].d, ncap[67].last}), 32'({8'hCD, 1'b1}));
    end
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eth_frame_sequencer.md
ETH_FRAME_SEQUENCER -- requirements
Module: eth_frame_sequencer

Interface
REQ-001 Parameter PACKET_PAYLOAD_BYTES, default 128, payload bytes per frame; legal range 46..1500, elaboration error otherwise.
REQ-002 Parameter IFG_BYTES, default 12, idle cycles inserted after each frame.
REQ-003 Parameter INCLUDE_FCS, default 1, 1 = append CRC-32 FCS, 0 = omit FCS state.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  request one frame; sampled only in IDLE.
REQ-007 header_in  input  ethernet_header (ethernet_header_pkg)  destination MAC, source MAC, type/length, each as byte arrays, index 0 sent first.
REQ-008 payload_data  input  8  payload byte from sample buffer.
REQ-009 payload_valid  input  1  payload_data valid.
REQ-010 payload_ready  output  1  payload byte consumed this cycle when payload_valid also high.
REQ-011 tx_data  output  8  frame byte to PHY/MAC.
REQ-012 tx_valid  output  1  tx_data valid.
REQ-013 tx_ready  input  1  downstream accepts byte when tx_valid also high.
REQ-014 tx_last  output  1  marks final byte of frame (last FCS byte, or last payload byte if INCLUDE_FCS=0).
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 States: IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, FCS, IFG; one byte counter shared across states, cleared on each state entry.
REQ-017 IDLE: start=1 -> latch header_in into internal register, init CRC to 0xFFFFFFFF, go to PREAMBLE next cycle; header_in changes after start do not affect the frame.
REQ-018 A byte "transfers" only on a cycle with tx_valid=1 and tx_ready=1; counters and CRC advance only on transfers.
REQ-019 PREAMBLE: tx_valid=1, tx_data=0x55, 7 transfers, then SFD.
REQ-020 SFD: tx_valid=1, tx_data=0xD5, 1 transfer, then HEADER.
REQ-021 HEADER: tx_valid=1, 14 transfers in order mac_destination[0..5], mac_source[0..5], eth_type_length[0..1], then PAYLOAD.
REQ-022 PAYLOAD: tx_valid=payload_valid, tx_data=payload_data, payload_ready=tx_ready (combinational pass-through); PACKET_PAYLOAD_BYTES transfers, then FCS (or IFG if INCLUDE_FCS=0).
REQ-023 payload_ready SHALL be 0 in every state other than PAYLOAD.
REQ-024 While tx_valid=1 and tx_ready=0 in states other than PAYLOAD, tx_data and tx_last SHALL hold stable.
REQ-025 CRC: IEEE 802.3 CRC-32, reflected polynomial 0xEDB88320, LSB-first byte update, computed over HEADER and PAYLOAD transfers only.
REQ-026 FCS: 4 transfers of the complemented CRC, least-significant byte first; tx_last=1 on the 4th; CRC register frozen during FCS.
REQ-027 IFG: tx_valid=0 for exactly IFG_BYTES cycles regardless of tx_ready, then IDLE; start during IFG ignored.
REQ-028 start while busy=1 SHALL be ignored (no queuing).
REQ-029 payload_valid=0 mid-payload: tx_valid=0, counter holds, no timeout; frame resumes when payload_valid returns.
REQ-030 Frame length on tx: 8 + 14 + PACKET_PAYLOAD_BYTES + 4*INCLUDE_FCS transfers.
REQ-031 tx_last=0 in all other bytes and states.

Reset
REQ-032 rst_n=0 at a clock edge -> next cycle state=IDLE, counter=0, CRC=0xFFFFFFFF, tx_valid=0, tx_data=0x00, tx_last=0, payload_ready=0, busy=0.
REQ-033 Reset mid-frame abandons the frame without emitting remaining bytes; no partial frame resumes after reset release.
REQ-034 First start honoured on the first cycle with rst_n=1 in IDLE.

Verification
REQ-035 Default params, tx_ready=1, payload bytes 0x00..0x7F always valid, start pulse -> 154 transfers: 7x0x55, 0xD5, header bytes 8C 47 BE 1C 82 ED 00 18 3E 01 EB 6E 00 80, payload, FCS; tx_last on byte 154; then 12 idle cycles.
REQ-036 FCS check: CRC-32 over header+payload+FCS bytes of scenario 1 -> residue 0xDEBB20E3; FCS equals software CRC-32 of the 142 header+payload bytes.
REQ-037 Random tx_ready (50%) and payload_valid gaps -> byte stream identical to scenario 1; no tx_data change while tx_valid&&!tx_ready outside PAYLOAD; no payload byte lost or duplicated.
REQ-038 start held high continuously -> frames separated by exactly 12 idle cycles plus 1 IDLE cycle; header_in change after start affects only the next frame.
REQ-039 rst_n=0 during payload byte 40 -> next cycle tx_valid=0, busy=0, payload_ready=0; subsequent start produces a complete correct 154-byte frame.
REQ-040 INCLUDE_FCS=0, PACKET_PAYLOAD_BYTES=46 -> 68 transfers, tx_last on last payload byte, header bytes 13..14 = 0x00 0x2E.
